mem_responder: RTL

- Memory-side endpoint of the CPU load/store and fetch interface; answers requests issued by the pipeline's memory stage.
- Accepts one request at a time over a valid/ready handshake.
- Holds the request for a fixed, parameterised latency, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency memory model so that stall and handshake logic in the CPU can be exercised.

---
 rtl/mem_if_pkg.sv | 32 +++
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: FSM states, request types and defaults.
// The MEM_RESP_ERR_EN build option is handled in mem_responder itself.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] NOP   = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam int WORD_BYTES      = 4;
    localparam int DEFAULT_DEPTH   = 16384;
    localparam int DEFAULT_LATENCY = 4;

    // A request with both flags set is a store.
    function automatic logic [1:0] reqType(input logic rd, input logic wr);
        logic [1:0] t;
        if (wr) begin
            t = WRITE;
        end else if (rd) begin
            t = READ;
        end else begin
            t = NOP;
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM: combinational index, write on wrEn, registered read on rdEn.
// Deliberately unreset so committed data survives a responder reset.
module mem_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic                     rdEn,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wrData,
    output logic [31:0]              rdData
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdData_r;

    // Word storage and read-data capture.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[idx] <= wrData;
        end
        if (rdEn) begin
            rdData_r <= mem_r[idx];
        end
    end

    assign rdData = rdData_r;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory endpoint: one request at a time, valid/ready on both sides.
// Optional build macro MEM_RESP_ERR_EN adds resp_err and address/type error checking.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef MEM_RESP_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       ONE_CYCLE = (LATENCY == 1);

    state_t          state_r, stateNext_s;
    logic [3:0]      cnt_r, cntNext_s;
    logic [AW-1:0]   idx_r, reqIdx_s, arrIdx_s;
    logic [1:0]      type_r, reqType_s, curType_s;
    logic            err_r, reqErr_s, curErr_s;
    logic            accept_s, enterResp_s, wrEn_s, rdEn_s;
    logic            reqReady_r, respValid_r, loadSel_r;
    logic [31:0]     arrRdata_s;

    assign reqIdx_s  = req_addr[AW+1:2];
    assign reqType_s = reqType(req_read, req_write);

`ifdef MEM_RESP_ERR_EN
    logic respErr_r;
    assign reqErr_s = (req_addr[1:0] != 2'b00)
                   || (req_addr[31:AW+2] != {(30-AW){1'b0}})
                   || (req_read && req_write);
`else
    logic unusedAddrBits_s;
    assign unusedAddrBits_s = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign reqErr_s = 1'b0;
`endif

    // With LATENCY==1 the array read happens on the accept edge, so use the live request.
    assign curType_s = (state_r == IDLE) ? reqType_s : type_r;
    assign curErr_s  = (state_r == IDLE) ? reqErr_s  : err_r;
    assign arrIdx_s  = (state_r == IDLE) ? reqIdx_s  : idx_r;

    assign wrEn_s = accept_s && (reqType_s == WRITE) && !reqErr_s;
    assign rdEn_s = enterResp_s && (curType_s == READ) && !curErr_s;

    // Next-state and latency counter logic.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        accept_s    = 1'b0;
        enterResp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && reqReady_r) begin
                    accept_s = 1'b1;
                    if (ONE_CYCLE) begin
                        stateNext_s = RESP;
                        enterResp_s = 1'b1;
                    end else begin
                        stateNext_s = WAIT;
                        cntNext_s   = CNT_INIT;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    stateNext_s = RESP;
                    enterResp_s = 1'b1;
                end else begin
                    cntNext_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = RESP;
                end
            end
            default: begin
                stateNext_s = IDLE;
                cntNext_s   = 4'd0;
            end
        endcase
    end

    // State, counter and handshake output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            reqReady_r  <= 1'b1;
            respValid_r <= 1'b0;
            loadSel_r   <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            cnt_r       <= cntNext_s;
            reqReady_r  <= (stateNext_s == IDLE);
            respValid_r <= (stateNext_s == RESP);
            if (enterResp_s) begin
                loadSel_r <= rdEn_s;
            end
        end
    end

    // Latched request, held while waiting for the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r  <= {AW{1'b0}};
            type_r <= NOP;
            err_r  <= 1'b0;
        end else if (accept_s) begin
            idx_r  <= reqIdx_s;
            type_r <= reqType_s;
            err_r  <= reqErr_s;
        end
    end

`ifdef MEM_RESP_ERR_EN
    // Error flag lives only for the duration of the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            respErr_r <= 1'b0;
        end else if (enterResp_s) begin
            respErr_r <= curErr_s;
        end else if (stateNext_s != RESP) begin
            respErr_r <= 1'b0;
        end
    end

    assign resp_err = respErr_r;
`endif

    mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .wrEn   (wrEn_s),
        .rdEn   (rdEn_s),
        .idx    (arrIdx_s),
        .wrData (req_wdata),
        .rdData (arrRdata_s)
    );

    // The array read register is unreset and also held across stores, so gate it here.
    assign req_ready  = reqReady_r;
    assign resp_valid = respValid_r;
    assign resp_rdata = loadSel_r ? arrRdata_s : 32'd0;

endmodule
